// File: rtl/dut_job_arbiter.sv
// Round-robin arbiter that serialises per-requester jobs onto one shared DUT port.
// Define DUT_ARB_WATCHDOG_EN to add a per-job watchdog that aborts stuck jobs via req_err.
module dut_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int ARG_W   = 32,
  parameter int TIMEOUT = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ARG_W-1:0] req_arg,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       req_err,
  output logic [ARG_W-1:0]      dut_arg,
  output logic                  dut_arg_stb,
  input  logic                  dut_arg_ack,
  input  logic                  dut_res_stb,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ARG_W-1:0]       arg_q, arg_d;
  logic                   stb_q, stb_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [NREQ-1:0]        err_q, err_d;

  logic [ARG_W-1:0]       arg_slice [NREQ];
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;
  logic                   grant_vld;
  logic [IDX_W-1:0]       next_ptr;
  logic                   wd_fire;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign arg_slice[i] = req_arg[i*ARG_W +: ARG_W];
  end

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign next_ptr = (idx_q == IDX_W'(NREQ-1)) ? '0 : idx_q + 1'b1;

`ifdef DUT_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             job_active;

  assign job_active = (state_q == ISSUE) || (state_q == WAIT_RES);
  assign wd_fire    = job_active && (wd_cnt_q == CNT_W'(TIMEOUT-1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == IDLE) begin
      wd_cnt_d = '0;
    end else if (job_active) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    arg_d    = arg_q;
    stb_d    = stb_q;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      IDLE: begin
        stb_d = 1'b0;
        if (grant_vld) begin
          state_d = ISSUE;
          idx_d   = grant_idx;
          arg_d   = arg_slice[grant_idx];
        end
      end
      ISSUE: begin
        stb_d = 1'b1;
        if (wd_fire) begin
          state_d       = DRAIN;
          stb_d         = 1'b0;
          err_d[idx_q]  = 1'b1;
          rr_ptr_d      = next_ptr;
        end else if (stb_q && dut_arg_ack) begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        stb_d = 1'b1;
        // A result arriving on the timeout cycle still counts as a completion.
        if (dut_res_stb) begin
          state_d       = DRAIN;
          stb_d         = 1'b0;
          done_d[idx_q] = 1'b1;
          rr_ptr_d      = next_ptr;
        end else if (wd_fire) begin
          state_d      = DRAIN;
          stb_d        = 1'b0;
          err_d[idx_q] = 1'b1;
          rr_ptr_d     = next_ptr;
        end
      end
      DRAIN: begin
        stb_d = 1'b0;
        if (!dut_arg_ack && !dut_res_stb) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      arg_q    <= '0;
      stb_q    <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      arg_q    <= arg_d;
      stb_q    <= stb_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign dut_arg     = arg_q;
  assign dut_arg_stb = stb_q;
  assign req_done    = done_q;
  assign req_err     = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dut_job_arbiter.sv
// Scoreboard bench for dut_job_arbiter: directed jobs against a small responder model of the shared DUT.
// Watchdog scenarios are compiled in when DUT_ARB_WATCHDOG_EN is defined.
module tb_dut_job_arbiter;

  localparam int NREQ    = 4;
  localparam int ARG_W   = 32;
  localparam int TIMEOUT = 100;

  typedef enum logic [1:0] {EV_ISSUE, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e         kind;
    int               idx;
    logic [ARG_W-1:0] arg;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*ARG_W-1:0] req_arg = '0;
  logic [NREQ-1:0]       req_done, req_err;
  logic [ARG_W-1:0]      dut_arg;
  logic                  dut_arg_stb, dut_arg_ack, dut_res_stb, busy;

  logic ack_q = 1'b0;
  logic res_q = 1'b0;
  logic force_res = 1'b0;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  logic             stb_prev = 1'b0;
  logic             arg_unstable = 1'b0;
  logic             multi_pulse = 1'b0;
  logic [ARG_W-1:0] held_arg = '0;

  dut_job_arbiter #(.NREQ(NREQ), .ARG_W(ARG_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_arg     (req_arg),
    .req_done    (req_done),
    .req_err     (req_err),
    .dut_arg     (dut_arg),
    .dut_arg_stb (dut_arg_stb),
    .dut_arg_ack (dut_arg_ack),
    .dut_res_stb (dut_res_stb),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Shared-DUT responder: ack follows stb by a cycle, result follows ack for small args.
  always @(posedge clk) begin
    ack_q <= dut_arg_stb;
    res_q <= dut_arg_stb && ack_q && (dut_arg < 10);
  end
  assign dut_arg_ack = ack_q;
  assign dut_res_stb = res_q | force_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_bit(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = NREQ-1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push(input ev_kind_e kind, input int idx, input logic [ARG_W-1:0] arg);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.arg  = arg;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind, input int idx, input logic [ARG_W-1:0] arg);
    ev_t e;
    check("event_expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (kind == e.kind) begin
        if (kind == EV_ISSUE) check("issue_arg", 64'(arg), 64'(e.arg));
        else                  check("pulse_idx", 64'(idx), 64'(e.idx));
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and pops the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if ($countones(req_done | req_err) > 1) multi_pulse = 1'b1;
      if (dut_arg_stb && !stb_prev) begin
        held_arg = dut_arg;
        observe(EV_ISSUE, -1, dut_arg);
      end else if (dut_arg_stb && (dut_arg !== held_arg)) begin
        arg_unstable = 1'b1;
      end
      if (req_done != '0) observe(EV_DONE, first_bit(req_done), '0);
      if (req_err  != '0) observe(EV_ERR,  first_bit(req_err),  '0);
      stb_prev = dut_arg_stb;
    end
  end

  task automatic set_arg(input int i, input logic [ARG_W-1:0] v);
    req_arg[i*ARG_W +: ARG_W] = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any done/err pulse; returns its index and cycles waited.
  task automatic wait_pulse(input int limit, output int idx, output int cycles);
    logic found = 1'b0;
    idx    = -1;
    cycles = 0;
    while (!found && cycles < limit) begin
      tick(1);
      cycles++;
      if ((req_done | req_err) != '0) begin
        found = 1'b1;
        idx   = first_bit(req_done | req_err);
      end
    end
    check("pulse_seen", 64'(found), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int idx, cyc;
    logic busy_drop, err_seen;

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stb", 64'(dut_arg_stb), 64'd0);
    check("rst_arg", 64'(dut_arg), 64'd0);
    check("rst_done", 64'(req_done), 64'd0);
    check("rst_err", 64'(req_err), 64'd0);
    rst = 1'b0;
    tick(1);

    // Single job: grant timing, latched argument, done latency, drain
    push(EV_ISSUE, 0, 32'h5);
    push(EV_DONE, 0, '0);
    set_arg(0, 32'h5);
    req = 4'b0001;
    tick(1);
    check("grant_busy", 64'(busy), 64'd1);
    check("grant_stb_low", 64'(dut_arg_stb), 64'd0);
    tick(1);
    check("stb_high", 64'(dut_arg_stb), 64'd1);
    check("stb_arg", 64'(dut_arg), 64'h5);
    set_arg(0, 32'h77);
    wait_pulse(50, idx, cyc);
    check("done_latency", 64'(cyc), 64'd3);
    check("done_idx", 64'(idx), 64'd0);
    req = '0;
    tick(1);
    check("drain_busy", 64'(busy), 64'd1);
    tick(1);
    check("idle_busy", 64'(busy), 64'd0);

    // All four requesting from rr_ptr=0: strict rotation
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_arg(i, ARG_W'(i + 1));
      push(EV_ISSUE, i, ARG_W'(i + 1));
      push(EV_DONE, i, '0);
    end
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      wait_pulse(50, idx, cyc);
      check("rotation_idx", 64'(idx), 64'(i));
      if (idx >= 0) req[idx] = 1'b0;
    end

    // Requests re-raised after done[1]: pointer at 2 grants 2 before 0
    set_arg(0, 32'h6);
    set_arg(1, 32'h7);
    push(EV_ISSUE, 0, 32'h6);
    push(EV_DONE, 0, '0);
    push(EV_ISSUE, 1, 32'h7);
    push(EV_DONE, 1, '0);
    push(EV_ISSUE, 2, 32'h9);
    push(EV_DONE, 2, '0);
    push(EV_ISSUE, 0, 32'h8);
    push(EV_DONE, 0, '0);
    req = 4'b0011;
    wait_pulse(50, idx, cyc);
    req[0] = 1'b0;
    wait_pulse(50, idx, cyc);
    set_arg(0, 32'h8);
    set_arg(2, 32'h9);
    req = 4'b0101;
    wait_pulse(50, idx, cyc);
    check("rr_first", 64'(idx), 64'd2);
    req[2] = 1'b0;
    wait_pulse(50, idx, cyc);
    check("rr_second", 64'(idx), 64'd0);
    req = '0;
    tick(3);

    // Requester drops mid-job: job still completes
    set_arg(2, 32'h3);
    push(EV_ISSUE, 2, 32'h3);
    push(EV_DONE, 2, '0);
    req = 4'b0100;
    tick(4);
    req = '0;
    wait_pulse(50, idx, cyc);
    check("drop_done_idx", 64'(idx), 64'd2);
    tick(3);

    // Reset in WAIT_RES: job silently dropped, next grant from rr_ptr=0
    set_arg(1, 32'h4);
    set_arg(3, 32'h5);
    push(EV_ISSUE, 1, 32'h4);
    req = 4'b0010;
    tick(4);
    rst = 1'b1;
    req = 4'b1010;
    push(EV_ISSUE, 1, 32'h4);
    push(EV_DONE, 1, '0);
    push(EV_ISSUE, 3, 32'h5);
    push(EV_DONE, 3, '0);
    tick(1);
    check("midrst_stb", 64'(dut_arg_stb), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_pulse", 64'(req_done | req_err), 64'd0);
    rst = 1'b0;
    wait_pulse(50, idx, cyc);
    check("postrst_first", 64'(idx), 64'd1);
    req[1] = 1'b0;
    wait_pulse(50, idx, cyc);
    check("postrst_second", 64'(idx), 64'd3);
    req = '0;
    tick(3);

    // Job whose result never arrives
    set_arg(1, 32'h20);
    push(EV_ISSUE, 1, 32'h20);
`ifdef DUT_ARB_WATCHDOG_EN
    push(EV_ERR, 1, '0);
    req = 4'b0010;
    tick(1);
    wait_pulse(TIMEOUT + 50, idx, cyc);
    check("wd_latency", 64'(cyc), 64'(TIMEOUT));
    check("wd_err", 64'(req_err), 64'b0010);
    check("wd_no_done", 64'(req_done), 64'd0);
    req = '0;
    tick(3);

    // Result forced on the very cycle the watchdog expires: completion wins
    push(EV_ISSUE, 1, 32'h20);
    push(EV_DONE, 1, '0);
    req = 4'b0010;
    tick(1);
    tick(TIMEOUT - 1);
    force_res = 1'b1;
    tick(1);
    check("race_done", 64'(req_done), 64'b0010);
    check("race_no_err", 64'(req_err), 64'd0);
    force_res = 1'b0;
    req = '0;
    tick(3);
    check("race_idle", 64'(busy), 64'd0);
`else
    req = 4'b0010;
    tick(1);
    busy_drop = 1'b0;
    err_seen  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (!busy) busy_drop = 1'b1;
      if (req_err != '0) err_seen = 1'b1;
    end
    check("hang_busy_dropped", 64'(busy_drop), 64'd0);
    check("hang_err_seen", 64'(err_seen), 64'd0);
    do_reset();
    check("hang_rst_busy", 64'(busy), 64'd0);
`endif

    tick(2);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("arg_stable", 64'(arg_unstable), 64'd0);
    check("pulse_onehot", 64'(multi_pulse), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
